// File: rtl/vecunit_pkg.sv
// Shared types and field positions for the vector result writeback stage.
package vecunit_pkg;
  localparam int RES_W         = 34;
  localparam int RES_VALID_BIT = 33;
  localparam int RES_MASK_BIT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic        mask;
    logic [31:0] data;
  } wb_ent_t;
endpackage

// File: rtl/vec_res_fifo.sv
// Synchronous result FIFO; pointers carry an extra wrap bit to tell full from empty.
module vec_res_fifo
  import vecunit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_ent_t din_i,
  input  logic    pop_i,
  output wb_ent_t head_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  wb_ent_t     mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Storage is cleared too so the head (and thus write data) reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) rptr_q <= rptr_q + PTR_ONE;
    end
  end
endmodule

// File: rtl/vec_result_writeback.sv
// Buffers per-element results and writes mask-enabled ones to the VRF.
// Optional skipped-element counter enabled by VEC_WB_SKIP_CNT_EN.
module vec_result_writeback
  import vecunit_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int VLEN_MAX = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [4:0]       vd_i,
  input  logic [IDX_W:0]   vl_i,
  input  logic [RES_W-1:0] res_i,
  output logic             res_ready_o,
  output logic             wr_valid_o,
  input  logic             wr_ready_i,
  output logic [4:0]       wr_vd_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [31:0]      wr_data_o,
  output logic             busy_o,
`ifdef VEC_WB_SKIP_CNT_EN
  output logic [IDX_W:0]   skip_cnt_o,
`endif
  output logic             done_o
);
  localparam logic [IDX_W:0]   VL_MAX  = (IDX_W+1)'(VLEN_MAX);
  localparam logic [IDX_W:0]   VL_ONE  = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  wb_state_e        state_q;
  logic [4:0]       vd_q;
  logic [IDX_W:0]   vl_q;
  logic [IDX_W-1:0] idx_q;

  wb_ent_t head, din;
  logic    full, empty, push, pop, in_run, last;
  logic [IDX_W:0] vl_clamp;

  assign din      = '{mask: res_i[RES_MASK_BIT], data: res_i[31:0]};
  assign push     = res_i[RES_VALID_BIT] && !full;
  assign in_run   = (state_q == ST_RUN);
  // Masked-off heads retire without waiting on the register file.
  assign pop      = in_run && !empty && (!head.mask || wr_ready_i);
  assign last     = ({1'b0, idx_q} == (vl_q - VL_ONE));
  assign vl_clamp = (vl_i > VL_MAX) ? VL_MAX : vl_i;

  vec_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (din),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign res_ready_o = !full;
  assign wr_valid_o  = in_run && !empty && head.mask;
  assign wr_vd_o     = vd_q;
  assign wr_idx_o    = idx_q;
  assign wr_data_o   = head.data;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vd_q    <= '0;
      vl_q    <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          vd_q    <= vd_i;
          vl_q    <= vl_clamp;
          idx_q   <= '0;
          state_q <= (vl_i == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: if (pop) begin
          idx_q <= idx_q + IDX_ONE;
          if (last) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VEC_WB_SKIP_CNT_EN
  logic [IDX_W:0] skip_cnt_q;
  assign skip_cnt_o = skip_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               skip_cnt_q <= '0;
    else if (state_q == ST_IDLE && start_i) skip_cnt_q <= '0;
    else if (pop && !head.mask)            skip_cnt_q <= skip_cnt_q + VL_ONE;
  end
`endif
endmodule

// File: tb/tb_vec_result_writeback.sv
`define CHK(tag, o, e) begin checks++; if ((64'(o)) !== (64'(e))) begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, 64'(o), 64'(e)); end end
module tb_vec_result_writeback;
  logic        clk, rst, start_i, wr_ready_i;
  logic [4:0]  vd_i;
  logic [5:0]  vl_i;
  logic [33:0] res_i;
  logic        res_ready_o, wr_valid_o, busy_o, done_o;
  logic [4:0]  wr_vd_o, wr_idx_o;
  logic [31:0] wr_data_o;
`ifdef VEC_WB_SKIP_CNT_EN
  logic [5:0]  skip_cnt_o;
`endif
  int errors = 0, checks = 0;

  vec_result_writeback #(.DEPTH(4), .VLEN_MAX(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vd_i(vd_i), .vl_i(vl_i),
    .res_i(res_i), .res_ready_o(res_ready_o), .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i), .wr_vd_o(wr_vd_o), .wr_idx_o(wr_idx_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o),
`ifdef VEC_WB_SKIP_CNT_EN
    .skip_cnt_o(skip_cnt_o),
`endif
    .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] mk(input logic m, input logic [31:0] d);
    return {1'b1, m, d};
  endfunction

  task automatic chk_reset_vals(input string tag);
    `CHK({tag, "_rdy"},  res_ready_o, 1)
    `CHK({tag, "_wv"},   wr_valid_o, 0)
    `CHK({tag, "_vd"},   wr_vd_o, 0)
    `CHK({tag, "_idx"},  wr_idx_o, 0)
    `CHK({tag, "_data"}, wr_data_o, 0)
    `CHK({tag, "_busy"}, busy_o, 0)
    `CHK({tag, "_done"}, done_o, 0)
`ifdef VEC_WB_SKIP_CNT_EN
    `CHK({tag, "_skip"}, skip_cnt_o, 0)
`endif
  endtask

  initial begin
    rst = 1'b1; start_i = 0; vd_i = 0; vl_i = 0; res_i = '0; wr_ready_i = 0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    start_i = 1; vd_i = 3; vl_i = 4; wr_ready_i = 1; res_i = mk(1, 32'h3F80_0000);
    tick();
    start_i = 0;
    for (int i = 0; i < 4; i++) begin
      `CHK("basic_wv",   wr_valid_o, 1)
      `CHK("basic_vd",   wr_vd_o, 3)
      checks++;
      if (wr_idx_o !== 5'(i)) begin
        errors++;
        $error("FAIL basic_idx observed=%0h expected=%0h", wr_idx_o, i);
      end
      `CHK("basic_data", wr_data_o, 32'h3F80_0000 + i)
      `CHK("basic_done_lo", done_o, 0)
      res_i = (i < 3) ? mk(1, 32'h3F80_0001 + i) : '0;
      tick();
    end
    `CHK("basic_done", done_o, 1)
    `CHK("basic_wv_off", wr_valid_o, 0)
    `CHK("basic_busy_done", busy_o, 1)
    tick();
    `CHK("basic_done_pulse", done_o, 0)
    `CHK("basic_idle", busy_o, 0)

    res_i = mk(1, 32'hA0); tick();
    res_i = mk(0, 32'hA1); tick();
    res_i = mk(1, 32'hA2); tick();
    res_i = '0;
    `CHK("mask_rdy_3", res_ready_o, 1)
    `CHK("mask_idle_wv", wr_valid_o, 0)
    start_i = 1; vd_i = 9; vl_i = 3;
    tick();
    start_i = 0;
    `CHK("mask_wv0", wr_valid_o, 1)
    `CHK("mask_idx0", wr_idx_o, 0)
    `CHK("mask_data0", wr_data_o, 32'hA0)
    tick();
    `CHK("mask_wv1", wr_valid_o, 0)
    `CHK("mask_idx1", wr_idx_o, 1)
    tick();
    `CHK("mask_wv2", wr_valid_o, 1)
    `CHK("mask_idx2", wr_idx_o, 2)
    `CHK("mask_data2", wr_data_o, 32'hA2)
    tick();
    `CHK("mask_done", done_o, 1)
`ifdef VEC_WB_SKIP_CNT_EN
    `CHK("mask_skip", skip_cnt_o, 1)
`endif
    tick();
`ifdef VEC_WB_SKIP_CNT_EN
    `CHK("mask_skip_hold", skip_cnt_o, 1)
`endif

    wr_ready_i = 0; start_i = 1; vd_i = 7; vl_i = 5;
    tick();
    start_i = 0;
    `CHK("bp_empty_wv", wr_valid_o, 0)
    `CHK("bp_busy", busy_o, 1)
    for (int i = 0; i < 5; i++) begin
      res_i = mk(1, 32'hB0 + i);
      tick();
      `CHK("bp_wv_hold", wr_valid_o, 1)
      `CHK("bp_data_hold", wr_data_o, 32'hB0)
      `CHK("bp_idx_hold", wr_idx_o, 0)
      `CHK("bp_rdy", res_ready_o, (i < 3) ? 1 : 0)
    end
    wr_ready_i = 1;
    for (int j = 0; j < 5; j++) begin
      `CHK("bp_wv", wr_valid_o, 1)
      `CHK("bp_idx", wr_idx_o, j)
      `CHK("bp_data", wr_data_o, 32'hB0 + j)
      if (j == 0) `CHK("bp_rdy_full", res_ready_o, 0)
      if (j == 1) `CHK("bp_rdy_free", res_ready_o, 1)
      tick();
      if (j == 1) res_i = '0;
    end
    `CHK("bp_done", done_o, 1)
    tick();

    start_i = 1; vd_i = 4; vl_i = 0;
    tick();
    start_i = 0;
    `CHK("vl0_done", done_o, 1)
    `CHK("vl0_wv", wr_valid_o, 0)
    `CHK("vl0_busy", busy_o, 1)
    tick();
    `CHK("vl0_done_pulse", done_o, 0)
    `CHK("vl0_idle", busy_o, 0)

    start_i = 1; vd_i = 1; vl_i = 40; res_i = mk(1, 32'h100);
    tick();
    start_i = 0;
    for (int k = 0; k < 32; k++) begin
      `CHK("vl40_idx", wr_idx_o, k)
      checks++;
      if (wr_data_o !== 32'(32'h100 + k)) begin
        errors++;
        $error("FAIL vl40_data observed=%0h expected=%0h", wr_data_o, 32'h100 + k);
      end
      `CHK("vl40_notdone", done_o, 0)
      res_i = (k < 31) ? mk(1, 32'h101 + k) : '0;
      tick();
    end
    `CHK("vl40_done", done_o, 1)
    tick();
    `CHK("vl40_idle", busy_o, 0)

    start_i = 1; vd_i = 2; vl_i = 4; res_i = mk(1, 32'hE0);
    tick();
    start_i = 0; res_i = mk(1, 32'hE1);
    tick();
    `CHK("rst_pre_idx", wr_idx_o, 1)
    res_i = mk(1, 32'hE2);
    tick();
    rst = 1'b1; res_i = '0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    `CHK("rst_no_done", done_o, 0)
    `CHK("rst_no_wv", wr_valid_o, 0)
    start_i = 1; vd_i = 5; vl_i = 2; res_i = mk(1, 32'hF0);
    tick();
    start_i = 0; res_i = mk(1, 32'hF1);
    `CHK("post_idx0", wr_idx_o, 0)
    `CHK("post_data0", wr_data_o, 32'hF0)
    `CHK("post_vd", wr_vd_o, 5)
    tick();
    res_i = '0;
    `CHK("post_idx1", wr_idx_o, 1)
    `CHK("post_data1", wr_data_o, 32'hF1)
    tick();
    `CHK("post_done", done_o, 1)
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
